// File: rtl/epd_output_sequencer.sv
// EPD output sequencer: packs 2-bit drive codes into source bytes and sequences
// source/gate driver timing for one frame per start. Optional: EPD_MIRROR_EN.
module epd_output_sequencer #(
    parameter int LINE_BYTES = 400,
    parameter int V_ACTIVE   = 1200,
    parameter int HBLANK     = 16,
    parameter int VS_CYCLES  = 8,
    parameter int V_TAIL     = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] epd_sd,
    output logic       epd_sdclk,
    output logic       epd_sdle,
    output logic       epd_sdoe,
    output logic       epd_sdce_n,
    output logic       epd_gdclk,
    output logic       epd_gdsp,
    output logic       epd_gdoe,
    output logic       busy,
    output logic       frame_done
);
    localparam int BW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LW = $clog2(V_ACTIVE + V_TAIL + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_BYTES - 1);
    localparam logic [7:0]    VS_LAST   = 8'(VS_CYCLES - 1);
    localparam logic [7:0]    VS_HALF   = 8'(VS_CYCLES / 2);
    localparam logic [7:0]    HB_LAST   = 8'(HBLANK - 1);
    localparam logic [LW-1:0] LINES_ACT = LW'(V_ACTIVE);
    localparam logic [LW-1:0] LINES_ALL = LW'(V_ACTIVE + V_TAIL);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_SHIFT, S_LATCH, S_GATE, S_TAIL, S_DONE
    } state_t;

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] line_nxt;
    logic [7:0]    ph_cnt;
    logic          phase_b;
    logic [7:0]    sd_next;

    // The panel may be mounted with reversed source direction.
    always_comb begin
`ifdef EPD_MIRROR_EN
        sd_next = {pix_data[1:0], pix_data[3:2], pix_data[5:4], pix_data[7:6]};
`else
        sd_next = pix_data;
`endif
    end

    assign line_nxt = line_cnt + LW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            ph_cnt     <= '0;
            phase_b    <= 1'b0;
            pix_ready  <= 1'b0;
            epd_sd     <= '0;
            epd_sdclk  <= 1'b0;
            epd_sdle   <= 1'b0;
            epd_sdoe   <= 1'b0;
            epd_sdce_n <= 1'b1;
            epd_gdclk  <= 1'b0;
            epd_gdsp   <= 1'b0;
            epd_gdoe   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_VSYNC;
                    busy     <= 1'b1;
                    epd_gdsp <= 1'b1;
                    epd_sdoe <= 1'b1;
                    epd_gdoe <= 1'b1;
                    ph_cnt   <= '0;
                end
                S_VSYNC: if (ph_cnt == VS_LAST) begin
                    state      <= S_SHIFT;
                    epd_gdsp   <= 1'b0;
                    epd_gdclk  <= 1'b0;
                    line_cnt   <= '0;
                    byte_cnt   <= '0;
                    phase_b    <= 1'b0;
                    pix_ready  <= 1'b1;
                    epd_sdce_n <= 1'b0;
                end else begin
                    ph_cnt    <= ph_cnt + 8'd1;
                    epd_gdclk <= (ph_cnt + 8'd1) >= VS_HALF;
                end
                // Tail lines share the shift timing but never stall and never consume input.
                S_SHIFT, S_TAIL: if (!phase_b) begin
                    if (state == S_TAIL || pix_valid) begin
                        if (state == S_SHIFT) epd_sd <= sd_next;
                        epd_sdclk <= 1'b1;
                        pix_ready <= 1'b0;
                        phase_b   <= 1'b1;
                    end
                end else begin
                    epd_sdclk <= 1'b0;
                    phase_b   <= 1'b0;
                    if (byte_cnt == BYTE_LAST) begin
                        byte_cnt   <= '0;
                        state      <= S_LATCH;
                        epd_sdle   <= 1'b1;
                        epd_sdce_n <= 1'b1;
                    end else begin
                        byte_cnt  <= byte_cnt + BW'(1);
                        pix_ready <= (state == S_SHIFT);
                    end
                end
                S_LATCH: begin
                    state     <= S_GATE;
                    epd_sdle  <= 1'b0;
                    epd_gdclk <= 1'b1;
                    ph_cnt    <= '0;
                end
                S_GATE: if (ph_cnt == HB_LAST) begin
                    epd_gdclk <= 1'b0;
                    line_cnt  <= line_nxt;
                    if (line_nxt < LINES_ACT) begin
                        state      <= S_SHIFT;
                        pix_ready  <= 1'b1;
                        epd_sdce_n <= 1'b0;
                    end else if (line_nxt < LINES_ALL) begin
                        state      <= S_TAIL;
                        epd_sdce_n <= 1'b0;
                        epd_sd     <= '0;
                    end else begin
                        state      <= S_DONE;
                        epd_sdoe   <= 1'b0;
                        epd_gdoe   <= 1'b0;
                        epd_sd     <= '0;
                        frame_done <= 1'b1;
                    end
                end else begin
                    ph_cnt <= ph_cnt + 8'd1;
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_epd_output_sequencer.sv
// Scoreboard bench for epd_output_sequencer on a small 4x3 (+1 tail) frame.
module tb_epd_output_sequencer;
    localparam int LB = 4, VA = 3, HB = 4, VS = 8, VT = 1;

    logic       clk = 1'b0, rstn = 1'b0, start = 1'b0, pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic       pix_ready, epd_sdclk, epd_sdle, epd_sdoe, epd_sdce_n;
    logic       epd_gdclk, epd_gdsp, epd_gdoe, busy, frame_done;
    logic [7:0] epd_sd;

    epd_output_sequencer #(.LINE_BYTES(LB), .V_ACTIVE(VA), .HBLANK(HB),
                           .VS_CYCLES(VS), .V_TAIL(VT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .epd_sd(epd_sd),
        .epd_sdclk(epd_sdclk), .epd_sdle(epd_sdle), .epd_sdoe(epd_sdoe),
        .epd_sdce_n(epd_sdce_n), .epd_gdclk(epd_gdclk), .epd_gdsp(epd_gdsp),
        .epd_gdoe(epd_gdoe), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0, err_cnt = 0;
    logic [7:0] exp_q[$];
    int vmode = 0, beat_idx = 0;
    int sdle_cnt = 0, gate_cnt = 0, gate_hi = 0, vs_cnt = 0, vs_clk = 0, done_cnt = 0;
    logic hold_start = 1'b0, fr_done = 1'b0, first_seen = 1'b0;
    logic prev_sdclk = 1'b0, prev_gdclk = 1'b0, prev_gdsp = 1'b0;
    logic [7:0] dbase = '0, first_sd = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_sd(input logic [7:0] d);
        logic [7:0] r;
        r = d;
`ifdef EPD_MIRROR_EN
        for (int i = 0; i < 4; i++) r[2*i +: 2] = d[6-2*i +: 2];
`endif
        return r;
    endfunction

    task automatic monitor();
        logic [7:0] e;
        if (epd_gdsp && !prev_gdsp) begin
            sdle_cnt = 0; gate_cnt = 0; gate_hi = 0; vs_cnt = 0; vs_clk = 0;
            done_cnt = 0; first_seen = 1'b0;
        end
        if (epd_gdsp) begin
            vs_cnt++;
            if (epd_gdclk) vs_clk++;
        end else if (epd_gdclk) begin
            gate_hi++;
            if (!prev_gdclk) gate_cnt++;
        end
        if (epd_sdle) sdle_cnt++;
        if (frame_done) begin
            done_cnt++;
            fr_done = 1'b1;
            chk("done_sdoe", epd_sdoe, 0);
            chk("done_gdoe", epd_gdoe, 0);
            chk("done_sd", epd_sd, 0);
        end
        if (epd_sdclk && !prev_sdclk) begin
            if (sdle_cnt < VA) begin
                if (exp_q.size() == 0) chk("sd_extra_byte", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    if (!first_seen) begin first_sd = epd_sd; first_seen = 1'b1; end
                    chk("sd_byte", epd_sd, e);
                end
            end else begin
                chk("tail_sd", epd_sd, 0);
            end
        end
        if (busy && sdle_cnt == VA) chk("tail_ready", pix_ready, 0);
    endtask

    task automatic drive();
        case (vmode)
            0:       pix_valid = 1'b1;
            1:       pix_valid = !pix_valid;
            default: pix_valid = 1'($urandom_range(0, 1));
        endcase
        pix_data = dbase + 8'(beat_idx);
        if (pix_valid && pix_ready) begin
            exp_q.push_back(model_sd(pix_data));
            beat_idx++;
        end
        if (busy && !hold_start) start = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rstn) monitor();
        prev_sdclk = epd_sdclk; prev_gdclk = epd_gdclk; prev_gdsp = epd_gdsp;
        drive();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        fr_done = 1'b0;
        while (!fr_done && t < 3000) begin cycle(); t++; end
        chk("frame_timeout", fr_done, 1);
    endtask

    task automatic check_frame();
        chk("beats", beat_idx, LB*VA);
        chk("sdle_pulses", sdle_cnt, VA+VT);
        chk("gate_pulses", gate_cnt, VA+VT);
        chk("gate_hi_cycles", gate_hi, (VA+VT)*HB);
        chk("vs_cycles", vs_cnt, VS);
        chk("vs_gdclk_cycles", vs_clk, VS/2);
        chk("frame_done_cnt", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic start_frame(input int mode, input logic [7:0] base, input logic hold);
        vmode = mode; dbase = base; hold_start = hold;
        beat_idx = 0; exp_q.delete();
        start = 1'b1;
    endtask

    initial begin
        int t;
        repeat (3) cycle();
        chk("rst_sdce_n", epd_sdce_n, 1);
        chk("rst_outs", {pix_ready, epd_sd, epd_sdclk, epd_sdle, epd_sdoe, epd_gdclk,
                         epd_gdsp, epd_gdoe, busy, frame_done}, 0);
        rstn = 1'b1;

        // Held valid, incrementing data
        start_frame(0, 8'h00, 1'b0);
        wait_done();
        check_frame();
        cycle();
        chk("idle_busy", busy, 0);

        // Toggling valid; first byte doubles as the mirror check
        start_frame(1, 8'h1B, 1'b0);
        wait_done();
        check_frame();
`ifdef EPD_MIRROR_EN
        chk("mirror_1b", first_sd, 8'hE4);
`else
        chk("mirror_1b", first_sd, 8'h1B);
`endif
        cycle();

        // Random stalls
        start_frame(2, 8'h40, 1'b0);
        wait_done();
        check_frame();
        cycle();

        // Back-to-back with start held
        start_frame(0, 8'h80, 1'b1);
        wait_done();
        check_frame();
        cycle();
        chk("gap_busy", busy, 0);
        chk("gap_gdsp", epd_gdsp, 0);
        cycle();
        chk("b2b_gdsp", epd_gdsp, 1);
        chk("b2b_busy", busy, 1);
        hold_start = 1'b0;
        beat_idx = 0;
        wait_done();
        check_frame();
        cycle();

        // Async reset during line 3 shift
        start_frame(0, 8'hC0, 1'b0);
        t = 0;
        while (!(sdle_cnt == 2 && !epd_sdce_n && busy) && t < 1000) begin cycle(); t++; end
        chk("reach_line3", t < 1000, 1);
        repeat (2) cycle();
        #2 rstn = 1'b0;
        #1;
        chk("arst_sdoe", epd_sdoe, 0);
        chk("arst_gdoe", epd_gdoe, 0);
        chk("arst_sdce_n", epd_sdce_n, 1);
        chk("arst_busy", busy, 0);
        start = 1'b0;
        vmode = 0;
        exp_q.delete();
        repeat (3) cycle();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("post_rst_done", frame_done, 0);
            chk("post_rst_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
